// File: rtl/stall_ctrl_if.sv
// Decode-side handshake bundle between the D stage and the stall controller.
// The D stage drives the decoded instruction fields; the stall controller
// answers with the pipeline register enables/clears and the mult/div busy flag.
interface stall_ctrl_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       stall;
    logic       pc_en;
    logic       fd_en;
    logic       de_clr;
    logic       md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, pc_en, fd_en, de_clr, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, pc_en, fd_en, de_clr, md_busy
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller.
// Keeps a shadow copy of the E and M stage destination registers together
// with their remaining Tnew, and a countdown of the mult/div busy window.
// A D-stage instruction is held (PC and IF/ID frozen, bubble into ID/EX)
// whenever forwarding cannot supply one of its sources in time, or when it
// touches HI/LO while the multiply/divide unit is still working.
module stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input logic         clk,
    input logic         reset,
    stall_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } mdState_t;

    logic [4:0]       eDst_q, eDst_d;
    logic [1:0]       eTnew_q, eTnew_d;
    logic             eMd_q, eMd_d;
    logic             eDiv_q, eDiv_d;
    logic [4:0]       mDst_q, mDst_d;
    logic [1:0]       mTnew_q, mTnew_d;
    logic [CNT_W-1:0] mdCnt_q;
    logic [CNT_W-1:0] mdLoad;
    mdState_t         mdState_q;

    logic rawRs;
    logic rawRt;
    logic mdHaz;
    logic stallNow;

    // Hazard detection: a source stalls only if a producer in E or M will not
    // have its result ready by the time D needs it; $0 is never a hazard.
    always_comb begin
        rawRs = (bus.d_rs != 5'd0) &&
                (((eDst_q == bus.d_rs) && (eTnew_q > bus.d_tuse_rs)) ||
                 ((mDst_q == bus.d_rs) && (mTnew_q > bus.d_tuse_rs)));
        rawRt = (bus.d_rt != 5'd0) &&
                (((eDst_q == bus.d_rt) && (eTnew_q > bus.d_tuse_rt)) ||
                 ((mDst_q == bus.d_rt) && (mTnew_q > bus.d_tuse_rt)));
        mdHaz = bus.d_md_use && ((mdState_q == BUSY) || eMd_q);
        stallNow = rawRs || rawRt || mdHaz;
    end

    assign bus.stall   = stallNow;
    assign bus.pc_en   = ~stallNow;
    assign bus.fd_en   = ~stallNow;
    assign bus.de_clr  = stallNow;
    assign bus.md_busy = (mdState_q == BUSY);

    // Next shadow contents: a stalled D instruction becomes a bubble in E, and
    // whatever was in E moves to M with one cycle less to wait.
    always_comb begin
        eDst_d  = stallNow ? 5'd0 : bus.d_dst;
        eTnew_d = stallNow ? 2'd0 : bus.d_tnew;
        eMd_d   = stallNow ? 1'b0 : bus.d_md_start;
        eDiv_d  = stallNow ? 1'b0 : bus.d_md_div;
        mDst_d  = eDst_q;
        mTnew_d = (eTnew_q == 2'd0) ? 2'd0 : eTnew_q - 2'd1;
    end

    // Shadow scoreboard registers for the E and M stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            eDst_q  <= 5'd0;
            eTnew_q <= 2'd0;
            eMd_q   <= 1'b0;
            eDiv_q  <= 1'b0;
            mDst_q  <= 5'd0;
            mTnew_q <= 2'd0;
        end else begin
            eDst_q  <= eDst_d;
            eTnew_q <= eTnew_d;
            eMd_q   <= eMd_d;
            eDiv_q  <= eDiv_d;
            mDst_q  <= mDst_d;
            mTnew_q <= mTnew_d;
        end
    end

    assign mdLoad = eDiv_q ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

    // Busy window FSM: a start leaving E reloads the counter (even mid-count),
    // otherwise it counts down and drops back to IDLE on reaching zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdCnt_q   <= '0;
            mdState_q <= IDLE;
        end else if (eMd_q) begin
            mdCnt_q   <= mdLoad;
            mdState_q <= (mdLoad != '0) ? BUSY : IDLE;
        end else if (mdCnt_q != '0) begin
            mdCnt_q   <= mdCnt_q - 1'b1;
            mdState_q <= (mdCnt_q != CNT_W'(1)) ? BUSY : IDLE;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl.
// Reference model: a queue of issued instructions stamped with the cycle they
// entered E; remaining Tnew is derived from their age, and the mult/div unit
// is modelled as an absolute "busy until cycle" number.
module tb_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuseRs;
        logic [1:0] tuseRt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       mdStart;
        logic       mdDiv;
        logic       mdUse;
    } instr_t;

    typedef struct {
        logic [4:0] dst;
        int         tnew;
        int         eCycle;
        bit         isMd;
        bit         isDiv;
    } entry_t;

    logic clk;
    logic reset;
    stall_ctrl_if bus();

    stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     checks;
    int     errors;
    int     cyc;
    int     busyUntil;
    entry_t pipe[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit rawHaz(input logic [4:0] src, input logic [1:0] tuse);
        int age;
        int rem;
        if (src == 5'd0) return 1'b0;
        foreach (pipe[i]) begin
            age = cyc - pipe[i].eCycle;
            if (age >= 0 && age <= 1 && pipe[i].dst == src) begin
                rem = pipe[i].tnew - age;
                if (rem < 0) rem = 0;
                if (rem > int'(tuse)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit mdInE();
        foreach (pipe[i]) begin
            if (pipe[i].eCycle == cyc && pipe[i].isMd) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit modelStall();
        return rawHaz(bus.d_rs, bus.d_tuse_rs) || rawHaz(bus.d_rt, bus.d_tuse_rt) ||
               (bus.d_md_use && (mdInE() || cyc <= busyUntil));
    endfunction

    function automatic bit modelBusy();
        return cyc <= busyUntil;
    endfunction

    task automatic applyStimulus(input instr_t x);
        bus.d_rs       = x.rs;
        bus.d_rt       = x.rt;
        bus.d_tuse_rs  = x.tuseRs;
        bus.d_tuse_rt  = x.tuseRt;
        bus.d_dst      = x.dst;
        bus.d_tnew     = x.tnew;
        bus.d_md_start = x.mdStart;
        bus.d_md_div   = x.mdDiv;
        bus.d_md_use   = x.mdUse;
    endtask

    function automatic instr_t randInstr();
        instr_t x;
        x.rs      = 5'($urandom_range(0, 4));
        x.rt      = 5'($urandom_range(0, 4));
        x.tuseRs  = 2'($urandom_range(0, 3));
        x.tuseRt  = 2'($urandom_range(0, 3));
        x.dst     = 5'($urandom_range(0, 4));
        x.tnew    = 2'($urandom_range(0, 2));
        x.mdStart = ($urandom_range(0, 9) == 0);
        x.mdDiv   = 1'($urandom_range(0, 1));
        x.mdUse   = x.mdStart || ($urandom_range(0, 5) == 0);
        return x;
    endfunction

    // Advance one clock edge, updating the reference model with what D held.
    task automatic tick();
        bit         s;
        bit         rst;
        instr_t     cur;
        s   = modelStall();
        rst = reset;
        cur = '{bus.d_rs, bus.d_rt, bus.d_tuse_rs, bus.d_tuse_rt, bus.d_dst,
                bus.d_tnew, bus.d_md_start, bus.d_md_div, bus.d_md_use};
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            busyUntil = -1;
        end else begin
            foreach (pipe[i]) begin
                if (pipe[i].eCycle == cyc && pipe[i].isMd)
                    busyUntil = cyc + (pipe[i].isDiv ? DIV_N : MULT_N);
            end
            if (!s) pipe.push_back('{cur.dst, int'(cur.tnew), cyc + 1, cur.mdStart, cur.mdDiv});
        end
        cyc++;
        while (pipe.size() > 0 && cyc - pipe[0].eCycle > 1) void'(pipe.pop_front());
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(randInstr());
        tick();
        reset = 1'b0;
    endtask

    // Hold an instruction in D until the model accepts it, gathering DUT behaviour.
    task automatic holdInstr(input instr_t x, output int dutStalls, output int dutBusy,
                             output int diffCycles, output bit accepted);
        bit e;
        dutStalls  = 0;
        dutBusy    = 0;
        diffCycles = 0;
        accepted   = 1'b0;
        applyStimulus(x);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e = modelStall();
            if (bus.stall === 1'b1) dutStalls++;
            if (bus.md_busy === 1'b1) dutBusy++;
            if (bus.stall !== e || bus.md_busy !== modelBusy()) diffCycles++;
            tick();
            if (!e) begin
                accepted = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(randInstr());
        tick();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(randInstr());
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall);
            end
            checks++;
            if (bus.pc_en !== 1'b1 || bus.fd_en !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_enables: got pc_en=%b fd_en=%b expected 1/1", bus.pc_en, bus.fd_en);
            end
            checks++;
            if (bus.de_clr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_de_clr: got %b expected 0", bus.de_clr);
            end
            checks++;
            if (bus.md_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_md_busy: got %b expected 0", bus.md_busy);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        int st, bz, df;
        bit acc;
        for (int t = 1; t >= 0; t--) begin
            resetDut();
            holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
            holdInstr('{5'd8, 5'd0, 2'(t), 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
            checks++;
            if (st !== 2 - t) begin
                errors++;
                $display("[TB] FAIL load_use_tuse%0d_stalls: got %0d expected %0d", t, st, 2 - t);
            end
            checks++;
            if (df !== 0 || !acc) begin
                errors++;
                $display("[TB] FAIL load_use_tuse%0d_trace: got %0d differing cycles acc=%b expected 0 acc=1", t, df, acc);
            end
        end
        // Same hazard through rt.
        resetDut();
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd2, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        holdInstr('{5'd3, 5'd12, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        checks++;
        if (st !== 2) begin
            errors++;
            $display("[TB] FAIL load_use_rt_stalls: got %0d expected 2", st);
        end
    endtask

    task automatic test_zero_reg();
        int st, bz, df;
        bit acc;
        resetDut();
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        holdInstr('{5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        checks++;
        if (st !== 0) begin
            errors++;
            $display("[TB] FAIL zero_reg_stalls: got %0d expected 0", st);
        end
        // Not-read source (tuse=3) against a pending Tnew=2 producer.
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        holdInstr('{5'd7, 5'd7, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0}, st, bz, df, acc);
        checks++;
        if (st !== 0) begin
            errors++;
            $display("[TB] FAIL tuse3_stalls: got %0d expected 0", st);
        end
    endtask

    task automatic test_mult();
        int st, bz, df;
        bit acc;
        resetDut();
        holdInstr('{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1}, st, bz, df, acc);
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd0, 1'b0, 1'b0, 1'b1}, st, bz, df, acc);
        checks++;
        if (st !== 6) begin
            errors++;
            $display("[TB] FAIL mult_mflo_stalls: got %0d expected 6", st);
        end
        checks++;
        if (bz !== 5) begin
            errors++;
            $display("[TB] FAIL mult_busy_cycles: got %0d expected 5", bz);
        end
        checks++;
        if (df !== 0 || !acc) begin
            errors++;
            $display("[TB] FAIL mult_trace: got %0d differing cycles acc=%b expected 0 acc=1", df, acc);
        end
    endtask

    task automatic test_back_to_back();
        int st, bz, df;
        bit acc;
        resetDut();
        holdInstr('{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1}, st, bz, df, acc);
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1}, st, bz, df, acc);
        checks++;
        if (st !== 11) begin
            errors++;
            $display("[TB] FAIL div_mfhi_stalls: got %0d expected 11", st);
        end
        checks++;
        if (bz !== 10) begin
            errors++;
            $display("[TB] FAIL div_busy_cycles: got %0d expected 10", bz);
        end
        resetDut();
        holdInstr('{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1}, st, bz, df, acc);
        holdInstr('{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1}, st, bz, df, acc);
        checks++;
        if (st !== 11) begin
            errors++;
            $display("[TB] FAIL div_div_stalls: got %0d expected 11", st);
        end
        holdInstr('{5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1}, st, bz, df, acc);
        checks++;
        if (st !== 11 || df !== 0) begin
            errors++;
            $display("[TB] FAIL second_div_mfhi: got %0d stalls %0d diffs expected 11 stalls 0 diffs", st, df);
        end
    endtask

    task automatic test_reset_mid_div();
        resetDut();
        applyStimulus('{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1});
        tick();
        applyStimulus('{5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_div_pending_stall: cycle %0d got %b expected 1", k, bus.stall);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.md_busy !== modelBusy() || bus.md_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_div_busy_before_reset: got %b expected 1", bus.md_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_div_after_reset: got busy=%b stall=%b expected 0/0", bus.md_busy, bus.stall);
        end
        tick();
    endtask

    task automatic test_random();
        bit e;
        int bad;
        bad = 0;
        resetDut();
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus(randInstr());
            @(negedge clk);
            e = modelStall();
            checks++;
            if (bus.stall !== e || bus.de_clr !== e || bus.pc_en !== !e || bus.fd_en !== !e ||
                bus.md_busy !== modelBusy()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random_cycle%0d: got stall=%b de_clr=%b pc_en=%b fd_en=%b busy=%b expected stall=%b busy=%b",
                             k, bus.stall, bus.de_clr, bus.pc_en, bus.fd_en, bus.md_busy, e, modelBusy());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    // Test sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busyUntil = -1;
        reset     = 1'b0;
        applyStimulus('0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mult();
        test_back_to_back();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
